// File: rtl/mux8_arb_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the MUX_8 round-robin arbiter.
package mux8_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    // Reset value of the last-owner pointer so input 0 is searched first.
    localparam logic [SEL_W-1:0] LAST_RST = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin search: first set req bit at or after start, wrapping mod 8.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = start + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter producing the select for an 8-input mux; all outputs registered.
// Hold-limit preemption is built only when MUX8_ARB_PREEMPT_EN is defined.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_valid,
    output logic             preempt
);

    arb_state_t       state, state_nxt;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] start;
    logic             found;
    logic [SEL_W-1:0] pick;
    logic             take;
    logic             go_idle;
    logic             rotate;
    logic [N_REQ-1:0] gnt_d;
    logic [SEL_W-1:0] sel_d;
    logic             valid_d;

    if (HOLD_MAX == 0 || HOLD_MAX > 15) begin : g_hold_range
        $error("HOLD_MAX must be within 1..15");
    end

    // Idle searches after the last owner; a live grant searches after the current owner.
    assign start = (state == IDLE) ? last + 1'b1 : sel + 1'b1;

    rr_pick8 u_pick (
        .req   (req),
        .start (start),
        .found (found),
        .idx   (pick)
    );

`ifdef MUX8_ARB_PREEMPT_EN
    logic [3:0] hold_cnt;
    logic       others;

    assign others = |(req & ~onehot8(sel));
    assign rotate = (hold_cnt == 4'(HOLD_MAX)) && others;

    // Counter saturates at HOLD_MAX so a lone owner is never rotated out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            if (take)
                hold_cnt <= 4'd1;
            else if (state == GRANT && hold_cnt < 4'(HOLD_MAX))
                hold_cnt <= hold_cnt + 1'b1;
            preempt <= (state == GRANT) && req[sel] && rotate;
        end
    end
`else
    assign rotate  = 1'b0;
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= LAST_RST;
            gnt       <= '0;
            sel       <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_d;
            sel       <= sel_d;
            gnt_valid <= valid_d;
            if (take)
                last <= pick;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        go_idle   = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    take      = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        go_idle   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (rotate) begin
                    take = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = gnt;
        sel_d   = sel;
        valid_d = gnt_valid;
        if (take) begin
            gnt_d   = onehot8(pick);
            sel_d   = pick;
            valid_d = 1'b1;
        end else if (go_idle) begin
            gnt_d   = '0;
            valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed vector table plus hold, async-reset and random fairness sequences for mux8_rr_arbiter.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       gnt_valid;
    logic       preempt;

    int total = 0;
    int bad   = 0;

    mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [7:0] eg, input logic [2:0] es,
                           input logic ev, input logic ep);
        chk({nm, ".gnt"}, 32'(gnt), 32'(eg));
        chk({nm, ".sel"}, 32'(sel), 32'(es));
        chk({nm, ".valid"}, 32'(gnt_valid), 32'(ev));
        chk({nm, ".preempt"}, 32'(preempt), 32'(ep));
    endtask

    int         hold_left[8];
    int         idle_left[8];
    int         waitc[8];
    logic       pvalid;
    logic [2:0] psel;
    logic [7:0] r;
    int         worst;

    initial begin
        vecs[0]  = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[1]  = '{8'h90, 8'h10, 3'd4, 1'b1};
        vecs[2]  = '{8'h80, 8'h80, 3'd7, 1'b1};
        vecs[3]  = '{8'h03, 8'h01, 3'd0, 1'b1};
        vecs[4]  = '{8'h03, 8'h01, 3'd0, 1'b1};
        vecs[5]  = '{8'h02, 8'h02, 3'd1, 1'b1};
        vecs[6]  = '{8'h00, 8'h00, 3'd1, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 3'd1, 1'b0};
        vecs[8]  = '{8'h21, 8'h20, 3'd5, 1'b1};
        vecs[9]  = '{8'h21, 8'h20, 3'd5, 1'b1};
        vecs[10] = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[11] = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[12] = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[13] = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[14] = '{8'h81, 8'h01, 3'd0, 1'b1};
        vecs[15] = '{8'h00, 8'h00, 3'd0, 1'b0};

        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].req);
            chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid, 1'b0);
        end

        // Two competing requesters held; owner 1 first (last owner was 0).
`ifdef MUX8_ARB_PREEMPT_EN
        for (int i = 0; i < 4; i++) begin
            step(8'h06);
            chk_out($sformatf("hold%0d", i), 8'h02, 3'd1, 1'b1, 1'b0);
        end
        step(8'h06);
        chk_out("preempt_rot", 8'h04, 3'd2, 1'b1, 1'b1);
        step(8'h06);
        chk_out("preempt_pulse_end", 8'h04, 3'd2, 1'b1, 1'b0);
`else
        for (int i = 0; i < 8; i++) begin
            step(8'h06);
            chk_out($sformatf("hold%0d", i), 8'h02, 3'd1, 1'b1, 1'b0);
        end
`endif
        for (int i = 0; i < 10; i++) begin
            step(8'h02);
            chk_out($sformatf("sole%0d", i), 8'h02, 3'd1, 1'b1, 1'b0);
        end

        // Asynchronous reset between edges clears outputs without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_out("rst_hold", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h81;
        @(posedge clk);
        #1;
        chk_out("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);
        step(8'h00);
        chk_out("post_rst_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            hold_left[i] = int'($urandom_range(1, 6));
            idle_left[i] = int'($urandom_range(0, 4));
            waitc[i]     = 0;
        end
        pvalid = gnt_valid;
        psel   = sel;
        for (int c = 0; c < 400; c++) begin
            r = '0;
            for (int i = 0; i < 8; i++) begin
                if (idle_left[i] == 0) r[i] = 1'b1;
                else idle_left[i]--;
            end
            step(r);
            chk("rand_onehot", 32'(gnt), gnt_valid ? 32'(8'h01 << sel) : 32'd0);
            chk("rand_owner_req", gnt_valid ? 32'(r[sel]) : 32'd1, 32'd1);
`ifndef MUX8_ARB_PREEMPT_EN
            chk("rand_no_preempt", 32'(preempt), 32'd0);
`endif
            if (gnt_valid && (!pvalid || sel != psel || preempt)) begin
                worst = 0;
                for (int j = 0; j < 8; j++) begin
                    if (j == int'(sel)) waitc[j] = 0;
                    else if (r[j]) waitc[j]++;
                    if (waitc[j] > worst) worst = waitc[j];
                end
                chk("rand_wait_le8", 32'(worst <= 8), 32'd1);
            end
            if (gnt_valid) begin
                hold_left[sel]--;
                if (hold_left[sel] <= 0) begin
                    hold_left[sel] = int'($urandom_range(1, 6));
                    idle_left[sel] = int'($urandom_range(1, 4));
                end
            end
            pvalid = gnt_valid;
            psel   = sel;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 4, max consecutive cycles one owner holds the grant while others wait (range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req  input  8  request per MUX_8 input (bit i = input i).
REQ-005 SHALL have port gnt  output  8  one-hot grant, all-zero when idle.
REQ-006 SHALL have port sel  output  3  binary index of owner, drives MUX_8 select.
REQ-007 SHALL have port gnt_valid  output  1  high while any grant is held.
REQ-008 SHALL have port preempt  output  1  one-cycle pulse when owner is forcibly rotated out.

Function
REQ-009 SHALL implement FSM states IDLE and GRANT, all outputs registered.
REQ-010 SHALL, in IDLE with req nonzero, select first set bit searching from (last+1) mod 8 upward with wrap, entering GRANT next edge (1-cycle request-to-grant latency).
REQ-011 SHALL remain in IDLE with gnt=0, sel unchanged, gnt_valid=0 while req=0.
REQ-012 SHALL, in GRANT, keep owner while req[owner]=1 and no preemption applies.
REQ-013 SHALL, when req[owner] drops with other requests pending, grant next requester (search from owner+1) on the same edge, no idle bubble.
REQ-014 SHALL, when req[owner] drops and req=0, return to IDLE on that edge.
REQ-015 SHALL keep gnt one-hot and equal to 1<<sel whenever gnt_valid=1.
REQ-016 SHALL update "last" pointer to owner index on every grant.
REQ-017 SHALL ignore req changes of non-owners during GRANT except for next-owner selection.
REQ-018 SHALL treat a sole requester's own bit as eligible after wrap (owner re-grant allowed when it is the only requester).

Reset
REQ-019 SHALL, on rst_n low (asynchronous, any state), force IDLE, gnt=0, sel=3'd0, gnt_valid=0, preempt=0, hold counter=0, last=3'd7 (so input 0 has first priority).
REQ-020 SHALL abort any grant in progress on reset mid-operation; first grant after release follows REQ-010.

Configuration
REQ-021 SHALL compile hold-limit preemption only when macro MUX8_ARB_PREEMPT_EN is defined.
REQ-022 SHALL, with MUX8_ARB_PREEMPT_EN, count owner hold cycles (reset on each new grant); when count reaches HOLD_MAX and any other req bit set, rotate to next requester on that edge and pulse preempt for one cycle.
REQ-023 SHALL, with MUX8_ARB_PREEMPT_EN, not preempt when owner is the only requester (counter saturates at HOLD_MAX).
REQ-024 SHALL, without MUX8_ARB_PREEMPT_EN, tie preempt to 0, omit counter, ignore HOLD_MAX.

Structure
REQ-025 SHALL place FSM state encoding, N_REQ=8 and SEL_W=3 constants in shared package mux8_arb_pkg.
REQ-026 SHALL use one sub-module rr_pick8 (combinational: req, start index -> found flag, index).
REQ-027 SHALL connect sel directly to MUX_8 select in the datapath top; arbiter contains no data path.

Verification
REQ-028 SHALL test: after reset, req=8'h01 -> next edge gnt=8'h01, sel=0, gnt_valid=1.
REQ-029 SHALL test: owner 0, req 8'h01->8'h90 -> same edge gnt=8'h10, sel=4; then req=8'h80 -> gnt=8'h80, sel=7, no idle cycle.
REQ-030 SHALL test: owner 7 drops, req=8'h03 -> wrap, gnt=8'h01, sel=0.
REQ-031 SHALL test (MUX8_ARB_PREEMPT_EN, HOLD_MAX=4): req=8'h06 held -> sel=1 for 4 cycles, then sel=2 with preempt=1 one cycle; req=8'h02 alone -> never preempted.
REQ-032 SHALL test: rst_n asserted mid-grant between edges -> outputs zero immediately, not waiting for clk.
REQ-033 SHALL test: all req sequences of 8 random-length holds -> gnt always one-hot or zero, matches sel, each pending requester served within 8 grants.
